// File: rtl/carbon_mode_stack.sv
// carbon_mode_stack: tier-transition controller with a DEPTH-entry stack of
// {previous tier, return PC} frames; one response or trap pulse per request.
module carbon_mode_stack #(
    parameter int DEPTH      = 4,
    parameter int TIER_W     = 8,
    parameter int PC_W       = 16,
    parameter int NUM_TIERS  = 3,
    parameter int RESET_TIER = 0,
    localparam int SP_W      = $clog2(DEPTH + 1),
    localparam int IW        = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [TIER_W-1:0] req_tier,
    input  logic [PC_W-1:0]   req_pc,
    input  logic [TIER_W-1:0] tier_ceiling,
    output logic              rsp_valid,
    output logic [PC_W-1:0]   rsp_pc,
    output logic              trap_valid,
    output logic [31:0]       trap_cause,
    output logic [TIER_W-1:0] cur_tier,
    output logic [SP_W-1:0]   sp
);
    typedef enum logic {IDLE, RESP} state_t;
    typedef struct packed {
        logic [TIER_W-1:0] tier;
        logic [PC_W-1:0]   pc;
    } frame_t;

    state_t state, state_next;
    frame_t stack [DEPTH];
    logic rsp_q, trap_q;
    logic accept, illegal, is_up, up_bad, full, empty, trap;
    logic [31:0] cause;
    logic [SP_W-1:0] sp_dec;
    logic [IW-1:0] push_idx, pop_idx;

    assign accept   = (state == IDLE) && req_valid && !flush;
    assign illegal  = req_op[1];
    assign is_up    = (req_op == 2'b00);
    assign up_bad   = (req_tier <= cur_tier) || (req_tier >= TIER_W'(NUM_TIERS)) || (req_tier > tier_ceiling);
    assign full     = (sp == SP_W'(DEPTH));
    assign empty    = (sp == '0);
    assign trap     = illegal || (is_up ? (up_bad || full) : empty);
    assign cause    = illegal ? 32'h15 : is_up ? (up_bad ? 32'h12 : 32'h13) : 32'h14;
    assign sp_dec   = sp - SP_W'(1);
    assign push_idx = sp[IW-1:0];
    assign pop_idx  = sp_dec[IW-1:0];

    // A flush in the response cycle suppresses the pulse combinationally.
    assign req_ready  = (state == IDLE) && !flush;
    assign rsp_valid  = rsp_q && !flush;
    assign trap_valid = trap_q && !flush;

    always_comb begin
        state_next = state;
        if (flush) state_next = IDLE;
        else if (state == RESP) state_next = IDLE;
        else if (accept) state_next = RESP;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else state <= state_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_tier   <= TIER_W'(RESET_TIER);
            sp         <= '0;
            rsp_q      <= 1'b0;
            trap_q     <= 1'b0;
            rsp_pc     <= '0;
            trap_cause <= '0;
        end else if (flush) begin
            cur_tier   <= TIER_W'(RESET_TIER);
            sp         <= '0;
            rsp_q      <= 1'b0;
            trap_q     <= 1'b0;
            rsp_pc     <= '0;
            trap_cause <= '0;
        end else if (accept) begin
            rsp_q  <= !trap;
            trap_q <= trap;
            if (trap) begin
                trap_cause <= cause;
            end else if (is_up) begin
                sp       <= sp + SP_W'(1);
                cur_tier <= req_tier;
                rsp_pc   <= req_pc;
            end else begin
                sp       <= sp_dec;
                cur_tier <= stack[pop_idx].tier;
                rsp_pc   <= stack[pop_idx].pc;
            end
        end else begin
            rsp_q  <= 1'b0;
            trap_q <= 1'b0;
        end
    end

    // Frame storage needs no reset: entries above sp are never read.
    always_ff @(posedge clk) begin
        if (accept && is_up && !trap) stack[push_idx] <= '{tier: cur_tier, pc: req_pc};
    end
endmodule
